// File: rtl/tile_pixel_generator.sv
`default_nettype none
// ============================================================================
// Module      : tile_pixel_generator
// Description : Double-buffered tile board renderer. Two ROWS x COLS boards of
//               3-bit colour indices; the front board is drawn through a
//               3-stage pixel pipeline with a frame border, the back board
//               takes writes, and the two exchange roles at frame end.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_pixel_generator #(
   parameter int BOARD_X0 = 280,
   parameter int BOARD_Y0 = 60,
   parameter int CELL     = 24,
   parameter int COLS     = 10,
   parameter int ROWS     = 20,
   parameter int BORDER   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] PixelCord_x,
   input  logic [9:0] PixelCord_y,
   input  logic       InViewableArea,
   input  logic       wr_en,
   input  logic [3:0] wr_col,
   input  logic [4:0] wr_row,
   input  logic [2:0] wr_data,
   input  logic       swap_req,
   output logic       swap_ack,
   output logic       ready,
   output logic [7:0] Pixel_Bus,
   output logic       Pixel_Bus_Enable
);

   localparam int CELLS = ROWS * COLS;
   localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam int PX1   = BOARD_X0 + COLS * CELL;
   localparam int PY1   = BOARD_Y0 + ROWS * CELL;

   typedef enum logic [1:0] {CLEAR, IDLE, SWAP_PEND} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] clr_addr, clr_addr_nxt;
   logic          front, front_nxt;     // 0: board0 displayed, 1: board1 displayed
   logic          frame_end;

   logic [2:0]    board0 [CELLS];
   logic [2:0]    board1 [CELLS];

   logic          wr_ok;
   logic [AW-1:0] wr_addr;

   logic          in_play, in_frame;
   logic [AW-1:0] cell_addr;

   logic          s1_valid, s1_play, s1_border;
   logic [AW-1:0] s1_addr;
   logic          s2_valid, s2_play, s2_border;
   logic [2:0]    s2_idx;
   logic [2:0]    rd_idx;

   assign frame_end = (PixelCord_x == 10'd799) && (PixelCord_y == 10'd599);

   assign wr_ok   = wr_en && ready && (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
   assign wr_addr = AW'(32'(wr_row) * COLS + 32'(wr_col));

   // Control state, clear pointer and front-board selection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= CLEAR;
         clr_addr <= '0;
         front    <= 1'b0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
         front    <= front_nxt;
      end
   end

   // Next-state logic; the swap happens only on the last pixel of a frame.
   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      front_nxt    = front;
      swap_ack     = 1'b0;
      ready        = 1'b1;
      case (state)
         CLEAR: begin
            ready = 1'b0;
            if (clr_addr == AW'(CELLS - 1)) begin
               state_nxt    = IDLE;
               clr_addr_nxt = '0;
            end else begin
               clr_addr_nxt = clr_addr + AW'(1);
            end
         end
         IDLE: begin
            if (swap_req) state_nxt = SWAP_PEND;
         end
         SWAP_PEND: begin
            if (frame_end) begin
               swap_ack  = 1'b1;
               front_nxt = ~front;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   // Board storage: clear both boards one cell per cycle, else write the back board.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         board0[clr_addr] <= 3'd0;
         board1[clr_addr] <= 3'd0;
      end else if (wr_ok) begin
         if (front) board0[wr_addr] <= wr_data;
         else       board1[wr_addr] <= wr_data;
      end
   end

   // Region and cell lookup by threshold comparison against cell edges (no divider).
   always_comb begin
      int xi, yi, col, row;
      xi  = int'(PixelCord_x);
      yi  = int'(PixelCord_y);
      col = 0;
      row = 0;
      for (int k = 1; k < COLS; k++) if (xi >= BOARD_X0 + k * CELL) col = k;
      for (int k = 1; k < ROWS; k++) if (yi >= BOARD_Y0 + k * CELL) row = k;
      in_play   = (xi >= BOARD_X0) && (xi < PX1) && (yi >= BOARD_Y0) && (yi < PY1);
      in_frame  = (xi >= BOARD_X0 - BORDER) && (xi < PX1 + BORDER) &&
                  (yi >= BOARD_Y0 - BORDER) && (yi < PY1 + BORDER);
      cell_addr = AW'(row * COLS + col);
   end

   assign rd_idx = front ? board1[s1_addr] : board0[s1_addr];

   // Stage 1: register visibility, region classification and cell address.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid  <= 1'b0;
         s1_play   <= 1'b0;
         s1_border <= 1'b0;
         s1_addr   <= '0;
      end else begin
         s1_valid  <= InViewableArea;
         s1_play   <= in_play;
         s1_border <= in_frame && !in_play;
         s1_addr   <= cell_addr;
      end
   end

   // Stage 2: read the front board; the board reads as index 0 while clearing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid  <= 1'b0;
         s2_play   <= 1'b0;
         s2_border <= 1'b0;
         s2_idx    <= 3'd0;
      end else begin
         s2_valid  <= s1_valid;
         s2_play   <= s1_play;
         s2_border <= s1_border;
         s2_idx    <= (state == CLEAR || !s1_play) ? 3'd0 : rd_idx;
      end
   end

   // Stage 3: palette lookup and output blanking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Pixel_Bus        <= 8'h00;
         Pixel_Bus_Enable <= 1'b0;
      end else begin
         Pixel_Bus_Enable <= s2_valid;
         if (!s2_valid) begin
            Pixel_Bus <= 8'h00;
         end else if (s2_play) begin
            case (s2_idx)
               3'd0:    Pixel_Bus <= 8'h00;
               3'd1:    Pixel_Bus <= 8'h1F;
               3'd2:    Pixel_Bus <= 8'hFC;
               3'd3:    Pixel_Bus <= 8'h83;
               3'd4:    Pixel_Bus <= 8'h1C;
               3'd5:    Pixel_Bus <= 8'hE0;
               3'd6:    Pixel_Bus <= 8'h03;
               default: Pixel_Bus <= 8'hF0;
            endcase
         end else if (s2_border) begin
            Pixel_Bus <= 8'hB6;
         end else begin
            Pixel_Bus <= 8'h00;
         end
      end
   end

endmodule
`default_nettype wire
